addr_bus_sequencer: RTL and testbench

Sequences the shared Addr bus between the instruction-fetch stage and the memory stage by driving the active-low control lines (a_addr_n, inc_n, dec_n) of the counter/address registers (PC, SP, SI, DI). It grants one register per cycle onto Addr. It also issues post-increment, post-decrement and pre-decrement pulses, so pushes, pops and fetches need no separate control logic. It sits between the pipeline control decode and the register bank.

---
 rtl/addr_seq_pkg.sv | 21 ++
 rtl/addr_seq_decode.sv | 22 ++
 rtl/addr_bus_sequencer.sv | 143 ++++++++++++++
 tb/tb_addr_bus_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/addr_seq_pkg.sv
// Shared types and defaults for the Addr bus sequencer.
// ADDR_SEQ_ANTISTARVE_EN (see addr_bus_sequencer) selects fetch anti-starvation.
package addr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PREDEC,
        MEM
    } state_e;

    typedef enum logic [1:0] {
        MODE_PLAIN,
        MODE_POSTINC,
        MODE_PREDEC,
        MODE_POSTDEC
    } mem_mode_e;

    localparam int PC_IDX_DEFAULT = 0;

endpackage

// File: rtl/addr_seq_decode.sv
// Index-to-select decoder with an active-low one-hot output.
// Output is all ones when disabled or when the index is out of range.
module addr_seq_decode #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [IDX_W-1:0]    idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] sel_n
);

    // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
    always_comb begin
        sel_n = '1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && (int'(idx) == i)) begin
                sel_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/addr_bus_sequencer.sv
// Grants one counter/address register per cycle onto Addr and pulses its inc/dec lines.
// Define ADDR_SEQ_ANTISTARVE_EN to force a fetch after STARVE_LIMIT memory grants.
module addr_bus_sequencer
    import addr_seq_pkg::*;
#(
    parameter int NUM_REGS     = 4,
    parameter int PC_IDX       = PC_IDX_DEFAULT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic                        fetch_req,
    output logic                        fetch_gnt,
    input  logic                        mem_req,
    input  logic [$clog2(NUM_REGS)-1:0] mem_reg,
    input  logic [1:0]                  mem_mode,
    output logic                        mem_gnt,
    output logic                        mem_busy,
    output logic [NUM_REGS-1:0]         a_addr_n,
    output logic [NUM_REGS-1:0]         inc_n,
    output logic [NUM_REGS-1:0]         dec_n
);

    localparam int REG_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [REG_W-1:0] PC_SEL     = REG_W'(PC_IDX);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
`ifdef ADDR_SEQ_ANTISTARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    mem_mode_e         mode_q, mode_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              force_fetch;

    logic              drive_en, inc_en, dec_en;
    logic [REG_W-1:0]  drive_idx;
    logic              fetch_gnt_q, fetch_gnt_d;
    logic              mem_gnt_q, mem_gnt_d;
    logic              mem_busy_q, mem_busy_d;
    logic [NUM_REGS-1:0] a_addr_n_q, a_addr_n_d;
    logic [NUM_REGS-1:0] inc_n_q, inc_n_d;
    logic [NUM_REGS-1:0] dec_n_q, dec_n_d;

    // Arbitration; the request fields are latched only when a memory access is chosen.
    always_comb begin
        state_d     = state_q;
        reg_d       = reg_q;
        mode_d      = mode_q;
        force_fetch = STARVE_EN && fetch_req && (starve_q == STARVE_MAX);
        if (state_q == PREDEC) begin
            state_d = MEM;
        end else if (force_fetch) begin
            state_d = FETCH;
        end else if (mem_req) begin
            reg_d   = mem_reg;
            mode_d  = mem_mode_e'(mem_mode);
            state_d = (mode_d == MODE_PREDEC) ? PREDEC : MEM;
        end else if (fetch_req) begin
            state_d = FETCH;
        end else begin
            state_d = IDLE;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (state_d == FETCH) begin
            starve_d = '0;
        end else if (STARVE_EN && (state_d == MEM) && fetch_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // NOTE: outputs are decoded from the next state and registered, so they are glitch-free
    // and change in lockstep with the state register.
    always_comb begin
        drive_en    = (state_d == FETCH) || (state_d == MEM);
        drive_idx   = (state_d == FETCH) ? PC_SEL : reg_d;
        inc_en      = (state_d == FETCH) || ((state_d == MEM) && (mode_d == MODE_POSTINC));
        dec_en      = (state_d == PREDEC) || ((state_d == MEM) && (mode_d == MODE_POSTDEC));
        fetch_gnt_d = (state_d == FETCH);
        mem_gnt_d   = (state_d == MEM);
        mem_busy_d  = (state_d == PREDEC);
    end

    addr_seq_decode #(.NUM_REGS(NUM_REGS), .IDX_W(REG_W)) u_addr_dec (
        .idx   (drive_idx),
        .en    (drive_en),
        .sel_n (a_addr_n_d)
    );

    addr_seq_decode #(.NUM_REGS(NUM_REGS), .IDX_W(REG_W)) u_inc_dec (
        .idx   (drive_idx),
        .en    (inc_en),
        .sel_n (inc_n_d)
    );

    addr_seq_decode #(.NUM_REGS(NUM_REGS), .IDX_W(REG_W)) u_dec_dec (
        .idx   (reg_d),
        .en    (dec_en),
        .sel_n (dec_n_d)
    );

    // Clear is asynchronous: an access caught in PREDEC is abandoned and MEM never follows.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            reg_q       <= '0;
            mode_q      <= MODE_PLAIN;
            starve_q    <= '0;
            fetch_gnt_q <= 1'b0;
            mem_gnt_q   <= 1'b0;
            mem_busy_q  <= 1'b0;
            a_addr_n_q  <= '1;
            inc_n_q     <= '1;
            dec_n_q     <= '1;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            mode_q      <= mode_d;
            starve_q    <= starve_d;
            fetch_gnt_q <= fetch_gnt_d;
            mem_gnt_q   <= mem_gnt_d;
            mem_busy_q  <= mem_busy_d;
            a_addr_n_q  <= a_addr_n_d;
            inc_n_q     <= inc_n_d;
            dec_n_q     <= dec_n_d;
        end
    end

    assign fetch_gnt = fetch_gnt_q;
    assign mem_gnt   = mem_gnt_q;
    assign mem_busy  = mem_busy_q;
    assign a_addr_n  = a_addr_n_q;
    assign inc_n     = inc_n_q;
    assign dec_n     = dec_n_q;

endmodule

// File: tb/tb_addr_bus_sequencer.sv
// Directed and random stimulus on two sequencer instances (4 and 3 registers) checked
// against a transaction-level model; the 3-register instance exercises out-of-range indices.
module tb_addr_bus_sequencer;

`ifdef ADDR_SEQ_ANTISTARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif
    localparam int STARVE_LIMIT = 4;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       fetch_req = 1'b0;
    logic       mem_req = 1'b0;
    logic [1:0] mem_reg = '0;
    logic [1:0] mem_mode = '0;

    logic       fetch_gnt4, mem_gnt4, mem_busy4;
    logic [3:0] a_addr_n4, inc_n4, dec_n4;
    logic       fetch_gnt3, mem_gnt3, mem_busy3;
    logic [2:0] a_addr_n3, inc_n3, dec_n3;

    always #5 clock = ~clock;

    addr_bus_sequencer #(.NUM_REGS(4), .PC_IDX(0), .STARVE_LIMIT(STARVE_LIMIT)) u_dut4 (
        .clock     (clock),
        .clear     (clear),
        .fetch_req (fetch_req),
        .fetch_gnt (fetch_gnt4),
        .mem_req   (mem_req),
        .mem_reg   (mem_reg),
        .mem_mode  (mem_mode),
        .mem_gnt   (mem_gnt4),
        .mem_busy  (mem_busy4),
        .a_addr_n  (a_addr_n4),
        .inc_n     (inc_n4),
        .dec_n     (dec_n4)
    );

    addr_bus_sequencer #(.NUM_REGS(3), .PC_IDX(2), .STARVE_LIMIT(STARVE_LIMIT)) u_dut3 (
        .clock     (clock),
        .clear     (clear),
        .fetch_req (fetch_req),
        .fetch_gnt (fetch_gnt3),
        .mem_req   (mem_req),
        .mem_reg   (mem_reg),
        .mem_mode  (mem_mode),
        .mem_gnt   (mem_gnt3),
        .mem_busy  (mem_busy3),
        .a_addr_n  (a_addr_n3),
        .inc_n     (inc_n3),
        .dec_n     (dec_n3)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Model: per instance, whether a pre-decremented access is still owed, its register,
    // and how many memory grants fetch has waited through.
    int n_regs [2] = '{4, 3};
    int pc_idx [2] = '{0, 2};
    bit owed [2];
    int owed_reg [2];
    int starve [2];
    int exp_an [2], exp_inc [2], exp_dec [2];
    bit exp_fg [2], exp_mg [2], exp_busy [2];

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int low_one(input int idx, input bit en, input int n);
        int m;
        m = (1 << n) - 1;
        if (en && idx < n) m = m & ~(1 << idx);
        return m;
    endfunction

    task automatic model_step(input int d, input bit fr, input bit mr, input int rg,
                              input int md, input bit clr);
        int  n;
        bit  do_fetch, do_mem;
        int  acc_reg, acc_mode;
        n = n_regs[d];
        exp_an[d] = (1 << n) - 1;
        exp_inc[d] = (1 << n) - 1;
        exp_dec[d] = (1 << n) - 1;
        exp_fg[d] = 1'b0;
        exp_mg[d] = 1'b0;
        exp_busy[d] = 1'b0;
        do_fetch = 1'b0;
        do_mem = 1'b0;
        acc_reg = 0;
        acc_mode = 0;
        if (clr) begin
            owed[d] = 1'b0;
            starve[d] = 0;
            return;
        end
        if (owed[d]) begin
            do_mem = 1'b1;
            acc_reg = owed_reg[d];
            acc_mode = 2;
            owed[d] = 1'b0;
        end else if (STARVE_EN && fr && starve[d] == STARVE_LIMIT) begin
            do_fetch = 1'b1;
        end else if (mr && md == 2) begin
            exp_dec[d] = low_one(rg, 1'b1, n);
            exp_busy[d] = 1'b1;
            owed[d] = 1'b1;
            owed_reg[d] = rg;
        end else if (mr) begin
            do_mem = 1'b1;
            acc_reg = rg;
            acc_mode = md;
        end else if (fr) begin
            do_fetch = 1'b1;
        end
        if (do_fetch) begin
            exp_an[d] = low_one(pc_idx[d], 1'b1, n);
            exp_inc[d] = low_one(pc_idx[d], 1'b1, n);
            exp_fg[d] = 1'b1;
            starve[d] = 0;
        end
        if (do_mem) begin
            exp_an[d] = low_one(acc_reg, 1'b1, n);
            exp_inc[d] = low_one(acc_reg, acc_mode == 1, n);
            exp_dec[d] = low_one(acc_reg, acc_mode == 3, n);
            exp_mg[d] = 1'b1;
            if (STARVE_EN && fr && starve[d] < STARVE_LIMIT) starve[d]++;
        end
    endtask

    task automatic check_all();
        check("d4.a_addr_n", int'(a_addr_n4), exp_an[0]);
        check("d4.inc_n", int'(inc_n4), exp_inc[0]);
        check("d4.dec_n", int'(dec_n4), exp_dec[0]);
        check("d4.fetch_gnt", int'(fetch_gnt4), int'(exp_fg[0]));
        check("d4.mem_gnt", int'(mem_gnt4), int'(exp_mg[0]));
        check("d4.mem_busy", int'(mem_busy4), int'(exp_busy[0]));
        check("d3.a_addr_n", int'(a_addr_n3), exp_an[1]);
        check("d3.inc_n", int'(inc_n3), exp_inc[1]);
        check("d3.dec_n", int'(dec_n3), exp_dec[1]);
        check("d3.fetch_gnt", int'(fetch_gnt3), int'(exp_fg[1]));
        check("d3.mem_gnt", int'(mem_gnt3), int'(exp_mg[1]));
        check("d3.mem_busy", int'(mem_busy3), int'(exp_busy[1]));
    endtask

    // Checks the outputs due now, then applies inputs for the next rising edge.
    task automatic cycle(input bit fr, input bit mr, input int rg, input int md, input bit clr);
        @(negedge clock);
        check_all();
        clear = clr;
        fetch_req = fr;
        mem_req = mr;
        mem_reg = rg[1:0];
        mem_mode = md[1:0];
        for (int d = 0; d < 2; d++) model_step(d, fr, mr, rg, md, clr);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) model_step(d, 1'b0, 1'b0, 0, 0, 1'b1);

        // Reset state.
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // Fetch held for three cycles.
        repeat (3) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Pre-decrement on register 1; request held through PREDEC, dropped in MEM.
        cycle(0, 1, 1, 2, 0);
        cycle(0, 1, 1, 2, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Fetch and post-increment memory request together: memory wins, fetch follows.
        cycle(1, 1, 2, 1, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Sustained contention between memory and fetch.
        repeat (12) cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Out-of-range index on the 3-register instance, with each mode.
        for (int m = 0; m < 4; m++) cycle(0, 1, 3, m, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Clear during PREDEC abandons the access.
        cycle(0, 1, 2, 2, 0);
        cycle(0, 1, 2, 2, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 99) == 0);
        end

        @(negedge clock);
        check_all();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
